// File: rtl/pmp_walker.sv
// Sequential PMP checker: walks PMP entries in priority order with two shared
// matchers (first byte, last byte) and returns allow/deny plus the deciding entry.

module pmp_entry #(
    parameter int unsigned PLEN            = 56,
    parameter int unsigned PMP_LEN         = 54,
    parameter int unsigned PMP_GRANULARITY = 0
) (
    input  logic [PLEN-1:0]    addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_prev_i,
    input  logic [1:0]         conf_addr_mode_i,
    output logic               match_o
);
    localparam int unsigned W = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;

    logic [W-1:0]       addr_w;
    logic [W-1:0]       base_w;
    logic [W-1:0]       prev_w;
    logic [W-1:0]       napot_size;
    logic [PMP_LEN-1:0] trailing;

    always_comb begin
        addr_w   = W'(addr_i);
        base_w   = W'({conf_addr_i, 2'b00});
        prev_w   = W'({conf_addr_prev_i, 2'b00});
        // trailing ones of pmpaddr plus the first zero give the NAPOT region size
        trailing   = conf_addr_i ^ (conf_addr_i + PMP_LEN'(1));
        napot_size = W'({trailing, 2'b11});
        match_o  = 1'b0;
        case (conf_addr_mode_i)
            2'b01:   match_o = (addr_w >= prev_w) && (addr_w < base_w);
            2'b10:   match_o = (PMP_GRANULARITY == 0) && (addr_w[W-1:2] == base_w[W-1:2]);
            2'b11:   match_o = (addr_w & ~napot_size) == (base_w & ~napot_size);
            default: match_o = 1'b0;
        endcase
    end
endmodule

module pmp_walker #(
    parameter int unsigned PLEN           = 56,
    parameter int unsigned PMP_LEN        = 54,
    parameter int unsigned NR_ENTRIES     = 16,
    parameter int unsigned PMPGranularity = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [PLEN-1:0]               req_addr_i,
    input  logic [12:0]                   req_len_i,
    input  logic [1:0]                    req_access_i,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
    input  logic [NR_ENTRIES*8-1:0]       conf_cfg_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_allow_o,
    output logic                          rsp_hit_o,
    output logic [$clog2(NR_ENTRIES)-1:0] rsp_idx_o
);
    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t             state;
    logic [PLEN-1:0]    addr_q;
    logic [PLEN-1:0]    last_q;
    logic [1:0]         access_q;
    logic [IDX_W-1:0]   idx_q;
    logic               ovf_q;
    logic [PLEN:0]      last_full;

    logic [PMP_LEN-1:0] addr_arr [NR_ENTRIES];
    logic [7:0]         cfg_arr  [NR_ENTRIES];
    logic [PMP_LEN-1:0] cur_addr;
    logic [PMP_LEN-1:0] prev_addr;
    logic [7:0]         cur_cfg;
    logic               match_a;
    logic               match_b;
    logic               unused_cfg;

    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_unpack
        assign addr_arr[i] = conf_addr_i[i*PMP_LEN +: PMP_LEN];
        assign cfg_arr[i]  = conf_cfg_i[i*8 +: 8];
    end

    always_comb begin
        cur_addr  = addr_arr[idx_q];
        cur_cfg   = cfg_arr[idx_q];
        prev_addr = (idx_q == '0) ? '0 : addr_arr[idx_q - 1'b1];
        last_full = {1'b0, req_addr_i} + (PLEN+1)'(req_len_i);
    end

    assign unused_cfg  = ^{cur_cfg[7:5], cur_cfg[2]};
    assign req_ready_o = (state == IDLE) && !rst_i;

    pmp_entry #(
        .PLEN            (PLEN),
        .PMP_LEN         (PMP_LEN),
        .PMP_GRANULARITY (PMPGranularity)
    ) u_entry_first (
        .addr_i           (addr_q),
        .conf_addr_i      (cur_addr),
        .conf_addr_prev_i (prev_addr),
        .conf_addr_mode_i (cur_cfg[4:3]),
        .match_o          (match_a)
    );

    pmp_entry #(
        .PLEN            (PLEN),
        .PMP_LEN         (PMP_LEN),
        .PMP_GRANULARITY (PMPGranularity)
    ) u_entry_last (
        .addr_i           (last_q),
        .conf_addr_i      (cur_addr),
        .conf_addr_prev_i (prev_addr),
        .conf_addr_mode_i (cur_cfg[4:3]),
        .match_o          (match_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_allow_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_idx_o   <= '0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q   <= req_addr_i;
                        last_q   <= last_full[PLEN-1:0];
                        ovf_q    <= last_full[PLEN];
                        access_q <= req_access_i;
                        idx_q    <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    // a wrapping access spends one cycle here so its response
                    // timing matches an entry-0 decision, but no entry is consulted
                    if (ovf_q) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_allow_o <= 1'b0;
                        rsp_hit_o   <= 1'b0;
                        rsp_idx_o   <= '0;
                    end else if (match_a && match_b) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_allow_o <= (access_q & ~cur_cfg[1:0]) == 2'b00;
                        rsp_hit_o   <= 1'b1;
                        rsp_idx_o   <= idx_q;
                    end else if (match_a ^ match_b) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_allow_o <= 1'b0;
                        rsp_hit_o   <= 1'b1;
                        rsp_idx_o   <= idx_q;
                    end else if (idx_q == IDX_W'(NR_ENTRIES - 1)) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_allow_o <= 1'b0;
                        rsp_hit_o   <= 1'b0;
                        rsp_idx_o   <= idx_q;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmp_walker.sv
// Directed self-checking bench for pmp_walker with 4 entries.

module tb_pmp_walker;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [55:0]     req_addr = '0;
    logic [12:0]     req_len = '0;
    logic [1:0]      req_access = '0;
    logic [N*54-1:0] conf_addr = '0;
    logic [N*8-1:0]  conf_cfg = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_allow;
    logic            rsp_hit;
    logic [1:0]      rsp_idx;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pmp_walker #(
        .PLEN           (56),
        .PMP_LEN        (54),
        .NR_ENTRIES     (N),
        .PMPGranularity (0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_access_i (req_access),
        .conf_addr_i  (conf_addr),
        .conf_cfg_i   (conf_cfg),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_allow_o  (rsp_allow),
        .rsp_hit_o    (rsp_hit),
        .rsp_idx_o    (rsp_idx)
    );

    task set_entry(input int i, input logic [53:0] a, input logic [7:0] c);
        conf_addr[i*54 +: 54] = a;
        conf_cfg[i*8 +: 8]    = c;
    endtask

    // lat counts clock edges after the accept edge until rsp_valid is seen
    task issue(input logic [55:0] a, input logic [12:0] l, input logic [1:0] acc, output int lat);
        @(negedge clk);
        req_addr = a; req_len = l; req_access = acc; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task handshake;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rsp_valid, rsp_hit, rsp_allow, rsp_idx} !== 5'b0) begin
            $display("FAIL reset_rsp: got %b expected 00000", {rsp_valid, rsp_hit, rsp_allow, rsp_idx});
        end else passed++;
        total++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b expected 0", req_ready);
        else passed++;
        @(negedge clk); rst = 1'b0; #1;
        total++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", req_ready);
        else passed++;
    endtask

    task test_napot;
        int lat;
        set_entry(0, 54'h3FF, 8'h19);
        set_entry(1, '0, 8'h00); set_entry(2, '0, 8'h00); set_entry(3, '0, 8'h00);
        issue(56'h100, 13'h3F, 2'b01, lat);
        total++;
        if (lat !== 1) $display("FAIL napot_rd_lat: got %0d expected 1", lat); else passed++;
        total++;
        if ({rsp_hit, rsp_allow, rsp_idx} !== 4'b1100)
            $display("FAIL napot_rd: got %b expected 1100", {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
        issue(56'h100, 13'h3F, 2'b10, lat);
        total++;
        if (lat !== 1 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b1000)
            $display("FAIL napot_wr: got lat=%0d %b expected lat=1 1000", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
    endtask

    task test_tor;
        int lat;
        set_entry(0, '0, 8'h00);
        set_entry(1, 54'h400, 8'h00);
        set_entry(2, 54'h800, 8'h0B);
        set_entry(3, '0, 8'h00);
        issue(56'h1F00, 13'hFF, 2'b10, lat);
        total++;
        if (lat !== 3) $display("FAIL tor_wr_lat: got %0d expected 3", lat); else passed++;
        total++;
        if ({rsp_hit, rsp_allow, rsp_idx} !== 4'b1110)
            $display("FAIL tor_wr: got %b expected 1110", {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
        issue(56'h1F00, 13'h100, 2'b10, lat);
        total++;
        if (lat !== 3 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b1010)
            $display("FAIL tor_partial: got lat=%0d %b expected lat=3 1010", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
        issue(56'h1000, 13'h0, 2'b00, lat);
        total++;
        if (lat !== 3 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b1110)
            $display("FAIL tor_zero_perm: got lat=%0d %b expected lat=3 1110", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
    endtask

    task test_na4;
        int lat;
        set_entry(3, 54'h800, 8'h11);
        issue(56'h2000, 13'h3, 2'b01, lat);
        total++;
        if (lat !== 4 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b1111)
            $display("FAIL na4_full: got lat=%0d %b expected lat=4 1111", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
        issue(56'h2002, 13'h3, 2'b01, lat);
        total++;
        if (lat !== 4 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b1011)
            $display("FAIL na4_partial: got lat=%0d %b expected lat=4 1011", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
        set_entry(3, '0, 8'h00);
    endtask

    task test_nomatch;
        int lat;
        issue(56'h8000_0000, 13'h0, 2'b01, lat);
        total++;
        if (lat !== 4 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b0011)
            $display("FAIL nomatch: got lat=%0d %b expected lat=4 0011", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
    endtask

    task test_overflow;
        int lat;
        issue(56'hFF_FFFF_FFFF_FFF0, 13'h1F, 2'b01, lat);
        total++;
        if (lat !== 1 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b0000)
            $display("FAIL overflow: got lat=%0d %b expected lat=1 0000", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        handshake();
    endtask

    task test_back_to_back;
        int lat;
        int bad;
        issue(56'h1800, 13'h0, 2'b10, lat);
        total++;
        if (lat !== 3 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b1110)
            $display("FAIL b2b_first: got lat=%0d %b expected lat=3 1110", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
        @(negedge clk);
        req_addr = 56'h8000_0000; req_len = '0; req_access = 2'b01; req_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if ({rsp_valid, rsp_hit, rsp_allow, rsp_idx, req_ready} !== 6'b111100) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL b2b_hold: got %0d unstable cycles expected 0", bad);
        else passed++;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL b2b_handshake: got %b expected 01", {rsp_valid, req_ready});
        else passed++;
        @(posedge clk); #1; req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0) $display("FAIL b2b_accept: got %b expected 0", req_ready);
        else passed++;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 4 || {rsp_hit, rsp_allow, rsp_idx} !== 4'b0011)
            $display("FAIL b2b_second: got lat=%0d %b expected lat=4 0011", lat, {rsp_hit, rsp_allow, rsp_idx});
        else passed++;
    endtask

    task test_reset_mid_scan;
        int seen;
        handshake();
        @(negedge clk);
        req_addr = 56'h8000_0000; req_len = '0; req_access = 2'b01; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rsp_valid, req_ready, rsp_idx} !== 4'b0000)
            $display("FAIL midscan_rst: got %b expected 0000", {rsp_valid, req_ready, rsp_idx});
        else passed++;
        rst = 1'b0; #1;
        total++;
        if ({req_ready, rsp_valid} !== 2'b10)
            $display("FAIL midscan_release: got %b expected 10", {req_ready, rsp_valid});
        else passed++;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL midscan_dropped: got %0d valid cycles expected 0", seen);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_napot();
        test_tor();
        test_na4();
        test_nomatch();
        test_overflow();
        test_back_to_back();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pmp_walker.md
Name: pmp_walker

Overview:
- Sequential PMP checker for the AXI IO-PMP request path; consumes per-entry match results from pmp_entry.
- Accepts one access (base address + byte length + R/W), scans PMP entries in priority order (0 first) using two shared pmp_entry instances (first byte, last byte).
- Returns allow/deny plus the deciding entry index.
- Sits between the AXI AR/AW capture logic (upstream) and the grant/error-response logic (downstream).

Parameters:
PLEN, 56, physical address width
PMP_LEN, 54, PMP address register width
NR_ENTRIES, 16, number of PMP entries (2..64)
PMPGranularity, 0, granularity G passed to pmp_entry (NA4 never matches for G>0)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&&ready
req_addr_i  in  PLEN  first byte address
req_len_i  in  13  byte count minus 1 (0 = 1 byte, max 4095 = 4 KiB)
req_access_i  in  2  required permissions, bit0=R, bit1=W
conf_addr_i  in  NR_ENTRIES*PMP_LEN  pmpaddr array, entry i at [i*PMP_LEN +: PMP_LEN]
conf_cfg_i  in  NR_ENTRIES*8  pmpcfg array: bit0 R, bit1 W, bit2 X (ignored), bits4:3 mode (OFF/TOR/NA4/NAPOT), bit7 L (ignored)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_allow_o  out  1  1 = access permitted
rsp_hit_o  out  1  1 = an entry decided (full or partial match)
rsp_idx_o  out  $clog2(NR_ENTRIES)  deciding entry index

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, rsp_valid_o=0, rsp_allow_o=0, rsp_hit_o=0, rsp_idx_o=0, scan counter=0. req_ready_o is 0 while rst_i is high.
- Reset mid-SCAN or mid-RESP: request silently dropped; no response issued.
- FSM states: IDLE, SCAN, RESP.
- IDLE:
  - req_ready_o=1.
  - On accept (edge E0): register addr, access, and last = addr + len, computed at PLEN+1 bits; idx=0.
  - If bit PLEN of last is set (wrap past top of address space): go to RESP with allow=0, hit=0, idx=0.
  - Otherwise go to SCAN.
- SCAN:
  - req_ready_o=0.
  - Entry j is evaluated combinationally in the cycle between edges E_j and E_(j+1).
  - Instance A checks addr and instance B checks last.
  - Both instances use conf_addr[j]; conf_addr_prev = 0 for j=0, else conf_addr[j-1]; mode from conf_cfg[j][4:3].
  - Full match (A&&B): go to RESP with hit=1, idx=j, allow = ((access & ~cfg[1:0]) == 0).
  - Partial match (A xor B): go to RESP with hit=1, idx=j, allow=0 (straddling access always denied).
  - No match: if j == NR_ENTRIES-1, go to RESP with hit=0, allow=0, idx=NR_ENTRIES-1 (default deny); else j++.
  - Latency: decision at entry k leads to rsp_valid_o high from edge E_(k+1). Overflow case: rsp_valid_o high from E1.
- RESP:
  - rsp_valid_o=1. rsp_allow_o, rsp_hit_o, rsp_idx_o held stable until handshake.
  - On rsp_ready_i at an edge: rsp_valid_o=0, return to IDLE.
  - Next request can be accepted earliest one cycle after the response handshake (no overlap).
- Configuration is sampled live during SCAN, not snapshotted. Upstream must hold config stable while req_ready_o=0.
- Entries in mode OFF and NA4 with G>0 never match.
- TOR entry 0 uses lower bound 0.
- Zero-permission request (access=00) on a full match gives allow=1.
- Response registers are updated only on FSM transitions into RESP.

Test Plan:
- 4 entries. E0 NAPOT pmpaddr=0x3FF (8 KiB at 0x0), cfg R. Read addr 0x100, len 0x3F -> rsp_valid at E1, hit=1, idx=0, allow=1. Same access as write -> allow=0, idx=0.
- E0 OFF, E1 OFF, E2 TOR pmpaddr[1]=0x400, pmpaddr[2]=0x800 (0x1000..0x1FFF), cfg RW. Write addr 0x1F00, len 0xFF -> rsp_valid at E3, idx=2, allow=1. Same with len 0x100 (last 0x2000) -> hit=1, idx=2, allow=0 (partial).
- No entry matches addr 0x8000_0000 -> rsp_valid at E4 (NR_ENTRIES=4), hit=0, allow=0, idx=3.
- addr = 2^56-16, len 0x1F (wraps) -> rsp_valid at E1, hit=0, allow=0; no scan performed.
- Hold rsp_ready_i=0 for 5 cycles: rsp_* stable and req_ready_o=0 throughout. A second request presented is accepted only after the response handshake.
- Assert rst_i during SCAN at entry 1 -> next cycle req_ready_o=1 after reset release, rsp_valid_o=0, and no response ever appears for the dropped request.
